// File: rtl/axis_mux_pkg.sv
// axis_mux_pkg: shared types and sizing helpers for the AXI-Stream packet arbiter
package axis_mux_pkg;
  typedef enum logic {ST_IDLE, ST_PKT} state_t;
  localparam int DATA_W_DEF = 32;
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after last_grant
module rr_arbiter #(
  parameter int N     = 2,
  parameter int SEL_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last_grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_valid
);
  // scan farthest-first so the nearest requester after last_grant wins
  always_comb begin
    grant_idx = '0;
    grant_valid = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last_grant) + k) % N]) begin
        grant_idx = SEL_W'((int'(last_grant) + k) % N);
        grant_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: packet-granular round-robin arbiter steering NUM_SRC AXI-Stream slaves onto one master
module axis_pkt_arbiter import axis_mux_pkg::*; #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = DATA_W_DEF,
  localparam int SEL_W  = sel_width(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]        s_axis_tvalid,
  input  logic [NUM_SRC-1:0]        s_axis_tlast,
  output logic [NUM_SRC-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic [SEL_W-1:0]          sel,
  output logic                      busy
);
  state_t state, state_nx;
  logic [SEL_W-1:0] grant, last_grant, pick_idx;
  logic pick_valid;
  rr_arbiter #(.N(NUM_SRC), .SEL_W(SEL_W)) u_rr (
    .req(s_axis_tvalid),
    .last_grant(last_grant),
    .grant_idx(pick_idx),
    .grant_valid(pick_valid)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      grant <= '0;
      last_grant <= SEL_W'(NUM_SRC - 1);
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && pick_valid) begin
        grant <= pick_idx;
        last_grant <= pick_idx;
      end
    end
  end
  // the master side is a pure combinational window onto the granted source
  always_comb begin
    state_nx = state;
    m_axis_tvalid = 1'b0;
    m_axis_tlast = 1'b0;
    m_axis_tdata = '0;
    s_axis_tready = '0;
    if (state == ST_IDLE) begin
      state_nx = pick_valid ? ST_PKT : ST_IDLE;
    end else begin
      m_axis_tvalid = s_axis_tvalid[grant];
      m_axis_tlast = s_axis_tlast[grant];
      m_axis_tdata = s_axis_tdata[int'(grant)*DATA_W +: DATA_W];
      s_axis_tready[grant] = m_axis_tready;
      state_nx = (m_axis_tvalid && m_axis_tready && m_axis_tlast) ? ST_IDLE : ST_PKT;
    end
  end
  assign sel = grant;
  assign busy = (state == ST_PKT);
endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb_axis_pkt_arbiter: directed tests with a per-cycle packet-level model for 2- and 4-source arbiters
module tb_axis_pkt_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] a_tdata = '0;
  logic [1:0]  a_tvalid = '0, a_tlast = '0, a_tready;
  logic [7:0]  a_mdata;
  logic        a_mvalid, a_mlast, a_mready = 1'b1, a_busy;
  logic [0:0]  a_sel;
  logic [31:0] b_tdata = '0;
  logic [3:0]  b_tvalid = '0, b_tlast = '0, b_tready;
  logic [7:0]  b_mdata;
  logic        b_mvalid, b_mlast, b_mready = 1'b1, b_busy;
  logic [1:0]  b_sel;

  axis_pkt_arbiter #(.NUM_SRC(2), .DATA_W(8)) dut_a (
    .clk(clk), .reset(rst), .s_axis_tdata(a_tdata), .s_axis_tvalid(a_tvalid),
    .s_axis_tlast(a_tlast), .s_axis_tready(a_tready), .m_axis_tdata(a_mdata),
    .m_axis_tvalid(a_mvalid), .m_axis_tlast(a_mlast), .m_axis_tready(a_mready),
    .sel(a_sel), .busy(a_busy));
  axis_pkt_arbiter #(.NUM_SRC(4), .DATA_W(8)) dut_b (
    .clk(clk), .reset(rst), .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid),
    .s_axis_tlast(b_tlast), .s_axis_tready(b_tready), .m_axis_tdata(b_mdata),
    .m_axis_tvalid(b_mvalid), .m_axis_tlast(b_mlast), .m_axis_tready(b_mready),
    .sel(b_sel), .busy(b_busy));

  int checks = 0, errors = 0, cyc = 0;
  bit armed = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // source beat stores: slots 0..1 feed dut_a, slots 2..5 feed dut_b
  logic [8:0] mem [6][64];
  int hd[6] = '{default: 0};
  int tl[6] = '{default: 0};

  task automatic push(input int slot, input logic last, input logic [7:0] d);
    mem[slot][tl[slot]] = {last, d};
    tl[slot]++;
  endtask

  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) if (a_tvalid[i] && a_tready[i] && hd[i] != tl[i]) hd[i]++;
    for (int i = 0; i < 4; i++) if (b_tvalid[i] && b_tready[i] && hd[2+i] != tl[2+i]) hd[2+i]++;
    #2;
    for (int i = 0; i < 2; i++) begin
      a_tvalid[i] = hd[i] != tl[i];
      {a_tlast[i], a_tdata[i*8 +: 8]} = (hd[i] != tl[i]) ? mem[i][hd[i]] : 9'd0;
    end
    for (int i = 0; i < 4; i++) begin
      b_tvalid[i] = hd[2+i] != tl[2+i];
      {b_tlast[i], b_tdata[i*8 +: 8]} = (hd[2+i] != tl[2+i]) ? mem[2+i][hd[2+i]] : 9'd0;
    end
  end

  logic [7:0] a_obs[$];
  int a_tim[$];
  int b_gr[$];
  logic [3:0] b_bad = '0;
  initial forever begin
    @(posedge clk);
    cyc++;
    if (a_mvalid && a_mready) begin
      a_obs.push_back(a_mdata);
      a_tim.push_back(cyc);
    end
    if (b_mvalid && b_mready && b_mlast) b_gr.push_back(int'(b_sel));
    if (armed) b_bad |= b_tready & 4'b0101;
  end

  // packet-level model: which source owns the master port, and whom rotation favours next
  bit mp[2] = '{0, 0};
  int mg[2] = '{0, 0};
  int mlg[2] = '{1, 3};

  task automatic model(input int d, input int n, input logic [31:0] td, input logic [3:0] tv,
                       input logic [3:0] tlst, input logic mr, input logic [7:0] md, input logic mv,
                       input logic ml, input logic [3:0] tr, input int s, input logic bz);
    bit f;
    int idx;
    if (armed) begin
      chk($sformatf("d%0d tvalid", d), mv, mp[d] ? tv[mg[d]] : 1'b0);
      chk($sformatf("d%0d tlast", d), ml, mp[d] ? tlst[mg[d]] : 1'b0);
      chk($sformatf("d%0d tdata", d), md, mp[d] ? td[mg[d]*8 +: 8] : 8'd0);
      chk($sformatf("d%0d tready", d), tr, (mp[d] && mr) ? (32'd1 << mg[d]) : 32'd0);
      chk($sformatf("d%0d sel", d), s, mg[d]);
      chk($sformatf("d%0d busy", d), bz, mp[d]);
    end
    if (rst) begin
      mp[d] = 0; mg[d] = 0; mlg[d] = n - 1;
    end else if (!mp[d]) begin
      f = 0;
      for (int k = 1; k <= n; k++) begin
        idx = (mlg[d] + k) % n;
        if (!f && tv[idx]) begin
          f = 1; mp[d] = 1; mg[d] = idx; mlg[d] = idx;
        end
      end
    end else if (tv[mg[d]] && mr && tlst[mg[d]]) begin
      mp[d] = 0;
    end
  endtask

  always @(negedge clk) begin
    model(0, 2, {16'd0, a_tdata}, {2'b0, a_tvalid}, {2'b0, a_tlast}, a_mready, a_mdata, a_mvalid,
          a_mlast, {2'b0, a_tready}, int'(a_sel), a_busy);
    model(1, 4, b_tdata, b_tvalid, b_tlast, b_mready, b_mdata, b_mvalid, b_mlast, b_tready,
          int'(b_sel), b_busy);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit done;
    done = 0;
    for (int n = 0; n < budget && !done; n++) begin
      step();
      done = !a_busy && !b_busy;
      for (int i = 0; i < 6; i++) if (hd[i] != tl[i]) done = 0;
    end
    chk({nm, " completes"}, done, 1'b1);
  endtask

  task automatic chk_obs(input string nm, input int n, input logic [7:0] exp [8]);
    chk({nm, " count"}, a_obs.size(), n);
    for (int i = 0; i < n; i++) chk($sformatf("%s beat%0d", nm, i), a_obs[i], exp[i]);
  endtask

  initial begin
    repeat (2) step();
    chk("rst sel", a_sel, 0);
    chk("rst busy", a_busy, 0);
    chk("rst mvalid", a_mvalid, 0);
    chk("rst mlast", a_mlast, 0);
    chk("rst mdata", a_mdata, 0);
    chk("rst tready", a_tready, 0);
    chk("rst b tready", b_tready, 0);
    armed = 1'b1;
    rst = 1'b0;
    // single 3-beat packet from source 0
    push(0, 0, 8'hA0); push(0, 0, 8'hA1); push(0, 1, 8'hA2);
    wait_done("t1", 20);
    chk_obs("t1", 3, '{8'hA0, 8'hA1, 8'hA2, 0, 0, 0, 0, 0});
    chk("t1 beat spacing", a_tim[2] - a_tim[0], 2);
    // both sources contend; last grant was 0 so source 1 goes first
    a_obs.delete(); a_tim.delete();
    for (int p = 0; p < 2; p++) begin
      push(0, 0, 8'h10); push(0, 1, 8'h11);
      push(1, 0, 8'h20); push(1, 1, 8'h21);
    end
    wait_done("t2", 40);
    chk_obs("t2", 8, '{8'h20, 8'h21, 8'h10, 8'h11, 8'h20, 8'h21, 8'h10, 8'h11});
    for (int i = 0; i < 7; i++) chk($sformatf("t2 gap%0d", i), a_tim[i+1] - a_tim[i], (i % 2) ? 2 : 1);
    // backpressure toggling during a 4-beat packet from source 1
    a_obs.delete(); a_tim.delete();
    push(1, 0, 8'h30); push(1, 0, 8'h31); push(1, 0, 8'h32); push(1, 1, 8'h33);
    for (int i = 0; i < 10; i++) begin
      a_mready = (i % 2) == 0;
      step();
    end
    a_mready = 1'b1;
    wait_done("t3", 20);
    chk_obs("t3", 4, '{8'h30, 8'h31, 8'h32, 8'h33, 0, 0, 0, 0});
    // back-to-back single-beat packets: one beat every second cycle
    a_obs.delete(); a_tim.delete();
    for (int i = 0; i < 4; i++) push(0, 1, 8'(8'h40 + i));
    wait_done("t4", 30);
    chk_obs("t4", 4, '{8'h40, 8'h41, 8'h42, 8'h43, 0, 0, 0, 0});
    for (int i = 0; i < 3; i++) chk($sformatf("t4 gap%0d", i), a_tim[i+1] - a_tim[i], 2);
    // reset while beat 2 of a 5-beat packet from source 1 is on the bus
    a_obs.delete(); a_tim.delete();
    for (int i = 0; i < 5; i++) push(1, i == 4, 8'(8'h50 + i));
    for (int i = 0; i < 10 && a_obs.size() < 1; i++) step();
    chk("t5 first beat", a_obs.size(), 1);
    rst = 1'b1;
    step();
    chk("t5 tready", a_tready, 0);
    chk("t5 mvalid", a_mvalid, 0);
    chk("t5 sel", a_sel, 0);
    chk("t5 busy", a_busy, 0);
    for (int i = 0; i < 6; i++) hd[i] = tl[i];
    rst = 1'b0;
    a_obs.delete(); a_tim.delete();
    push(0, 1, 8'h60); push(1, 1, 8'h70);
    wait_done("t5", 20);
    chk_obs("t5 after", 2, '{8'h60, 8'h70, 0, 0, 0, 0, 0, 0});
    // four-source arbiter with requests on sources 1 and 3 only
    for (int p = 0; p < 2; p++) begin
      push(3, 0, 8'h81); push(3, 1, 8'h82);
      push(5, 0, 8'h91); push(5, 1, 8'h92);
    end
    wait_done("t6", 40);
    chk("t6 count", b_gr.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t6 grant%0d", i), b_gr[i], (i % 2) ? 3 : 1);
    chk("t6 idle sources ready", b_bad, 0);
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
